// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: sequences test_mode, drives a Galois-LFSR pattern
// generator, compacts latency-aligned responses in a MISR, compares to GOLDEN.
module lbist_ctrl #(
    parameter int unsigned                  PRPG_WIDTH    = 32,
    parameter logic [PRPG_WIDTH-1:0]        PRPG_POLY     = PRPG_WIDTH'(32'h8020_0003),
    parameter logic [PRPG_WIDTH-1:0]        PRPG_SEED     = PRPG_WIDTH'(32'h0000_0001),
    parameter int unsigned                  MISR_WIDTH    = 32,
    parameter logic [MISR_WIDTH-1:0]        MISR_POLY     = MISR_WIDTH'(32'h8020_0003),
    parameter int unsigned                  N_PATTERNS    = 1024,
    parameter int unsigned                  SETTLE_CYCLES = 4,
    parameter int unsigned                  RESP_LATENCY  = 2,
    parameter logic [MISR_WIDTH-1:0]        GOLDEN        = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  test_mode_o,
    output logic [PRPG_WIDTH-1:0] pattern_o,
    output logic                  pattern_valid_o,
    input  logic [MISR_WIDTH-1:0] resp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [MISR_WIDTH-1:0] signature_o
);

    localparam int unsigned PCNT_W  = $clog2(N_PATTERNS + 1);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > RESP_LATENCY) ? SETTLE_CYCLES : RESP_LATENCY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(RESP_LATENCY - 1);
    localparam logic [PCNT_W-1:0] RUN_LAST   = PCNT_W'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_start_q;
    logic [PRPG_WIDTH-1:0]   r_prpg;
    logic [MISR_WIDTH-1:0]   r_misr;
    logic [PCNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]        r_cnt;
    logic [RESP_LATENCY-1:0] r_dl;
    logic                    r_active;
    logic                    r_valid;
    logic                    r_done;
    logic                    r_pass;
    logic                    r_fail;

    state_t                  w_state_nxt;
    logic                    w_launch;
    logic                    w_resp_qual;
    logic [PRPG_WIDTH-1:0]   w_prpg_nxt;
    logic [MISR_WIDTH-1:0]   w_misr_nxt;

    assign w_resp_qual = r_dl[RESP_LATENCY-1];
    assign w_prpg_nxt  = (r_prpg >> 1) ^ (r_prpg[0] ? PRPG_POLY : '0);
    assign w_misr_nxt  = ((r_misr >> 1) ^ (r_misr[0] ? MISR_POLY : '0)) ^ resp_i;

    // A start request is captured one cycle ahead of the launch into SETUP,
    // so the run ends at edge 2 + SETTLE + N_PATTERNS + LATENCY after start.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_start_q) begin
                        w_state_nxt = S_SETUP;
                        w_launch    = 1'b1;
                    end
                end
                S_SETUP:   if (r_cnt == SETUP_LAST) w_state_nxt = S_RUN;
                S_RUN:     if (r_pcnt == RUN_LAST)  w_state_nxt = S_DRAIN;
                S_DRAIN:   if (r_cnt == DRAIN_LAST) w_state_nxt = S_COMPARE;
                S_COMPARE: w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_prpg    <= PRPG_SEED;
            r_misr    <= '0;
            r_pcnt    <= '0;
            r_cnt     <= '0;
            r_dl      <= '0;
            r_active  <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start_i && !abort_i && (r_state == S_IDLE || r_state == S_DONE);
            r_active  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_valid   <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);

            if (r_state == S_COMPARE && w_state_nxt == S_DONE) begin
                r_pass <= (r_misr == GOLDEN);
                r_fail <= (r_misr != GOLDEN);
            end else if (w_state_nxt != S_DONE) begin
                r_pass <= 1'b0;
                r_fail <= 1'b0;
            end

            if (abort_i || w_launch) begin
                r_dl <= '0;
            end else begin
                r_dl[0] <= r_valid;
                for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
            end

            if (w_launch) begin
                r_prpg <= PRPG_SEED;
            end else if (r_state == S_RUN && !abort_i) begin
                r_prpg <= w_prpg_nxt;
            end

            if (w_launch) begin
                r_misr <= '0;
            end else if (w_resp_qual && !abort_i) begin
                r_misr <= w_misr_nxt;
            end

            if (abort_i || w_launch) begin
                r_cnt  <= '0;
                r_pcnt <= '0;
            end else begin
                unique case (r_state)
                    S_SETUP: r_cnt  <= (w_state_nxt == S_RUN) ? '0 : r_cnt + 1'b1;
                    S_RUN:   r_pcnt <= r_pcnt + 1'b1;
                    S_DRAIN: r_cnt  <= r_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign test_mode_o     = r_active;
    assign busy_o          = r_active;
    assign pattern_o       = r_prpg;
    assign pattern_valid_o = r_valid;
    assign done_o          = r_done;
    assign pass_o          = r_pass;
    assign fail_o          = r_fail;
    assign signature_o     = r_misr;

endmodule

// File: doc/lbist_ctrl.md
# lbist_ctrl

Parametrised logic-BIST controller for the gate-level RI5CY test wrapper. On `start_i` it raises `test_mode_o` toward the core and drives a pseudo-random stimulus bus from a configurable Galois LFSR (PRPG). It compacts the core's responses into a MISR with a configurable latency, then compares the final signature against a golden value. It generalises the fixed, externally driven `test_mode` hook into a self-sequencing BIST engine. Width, pattern count, settle time, response latency and polynomials are all parameters.

## Interface
- `PRPG_WIDTH`, 32: stimulus width.
- `PRPG_POLY`, 32'h8020_0003: Galois feedback mask of the PRPG.
- `PRPG_SEED`, 32'h0000_0001: PRPG seed, must be nonzero; this is the first pattern.
- `MISR_WIDTH`, 32: response/signature width.
- `MISR_POLY`, 32'h8020_0003: MISR feedback mask.
- `N_PATTERNS`, 1024: number of patterns per run, 1 or more.
- `SETTLE_CYCLES`, 4: cycles in `test_mode_o` before the first pattern, 1 or more.
- `RESP_LATENCY`, 2: cycles from pattern to its response, 1 or more.
- `GOLDEN`, 32'h0: expected signature, `MISR_WIDTH` bits.

Ports:
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `start_i`, in, 1: start request. Honoured only in IDLE or DONE.
- `abort_i`, in, 1: abort the run. Returns to IDLE.
- `test_mode_o`, out, 1: drives the core `test_mode` input.
- `pattern_o`, out, `PRPG_WIDTH`: current PRPG state.
- `pattern_valid_o`, out, 1: high in RUN.
- `resp_i`, in, `MISR_WIDTH`: core response.
- `busy_o`, out, 1: high in SETUP, RUN, DRAIN and COMPARE.
- `done_o`, out, 1: high in DONE.
- `pass_o`, out, 1: signature equals `GOLDEN`. Valid while `done_o` is high.
- `fail_o`, out, 1: signature differs from `GOLDEN`. Valid while `done_o` is high.
- `signature_o`, out, `MISR_WIDTH`: current MISR contents.

## Operation
- Reset values: state IDLE; PRPG = `PRPG_SEED`; MISR = 0; pattern counter, settle/drain counter and valid delay line = 0. All outputs are 0 except `pattern_o` = `PRPG_SEED`.
- FSM states: IDLE, SETUP, RUN, DRAIN, COMPARE, DONE.
  - IDLE to SETUP on `start_i`. On this transition: PRPG is loaded with the seed, MISR is cleared, the delay line is cleared and the pass/fail flags are cleared.
  - SETUP lasts exactly `SETTLE_CYCLES` cycles, then goes to RUN.
  - RUN lasts exactly `N_PATTERNS` cycles, then goes to DRAIN.
  - DRAIN lasts exactly `RESP_LATENCY` cycles, then goes to COMPARE.
  - COMPARE lasts 1 cycle and latches `pass` = (MISR == `GOLDEN`) and `fail` = the inverse. It then goes to DONE.
  - DONE holds its results. `start_i` in DONE behaves exactly as `start_i` in IDLE.
- `test_mode_o` is registered and is high in every state except IDLE and DONE.
- PRPG step, once per RUN cycle: next = (s >> 1) XOR (s[0] ? `PRPG_POLY` : 0). Pattern k (counting from 0) is the seed stepped k times.
- Valid delay line: a shift register of depth `RESP_LATENCY` fed by `pattern_valid_o`. Its output `resp_qual` marks the cycles whose `resp_i` must be compacted.
- MISR step, when `resp_qual` is high: next = ((m >> 1) XOR (m[0] ? `MISR_POLY` : 0)) XOR `resp_i`. Over one run exactly `N_PATTERNS` responses are compacted.
- `start_i` while `busy_o` is high is ignored.
- `abort_i` has priority over `start_i` and over every state transition. Any state goes to IDLE on the next edge: `test_mode_o` drops, the delay line is cleared, and `done_o`, `pass_o` and `fail_o` stay 0.
- If `rst_ni` is asserted mid-run, everything takes its reset values immediately, asynchronously.
- Counter widths: `$clog2(N_PATTERNS+1)` for the pattern counter; `$clog2(max(SETTLE_CYCLES, RESP_LATENCY)+1)` for the settle/drain counter. No wrap-around is possible within a run.

## Timing
- Take `start_i` as sampled high at edge 0.
- SETUP covers cycles 1 .. `SETTLE_CYCLES`.
- RUN covers the next `N_PATTERNS` cycles. `pattern_o` changes on every edge inside RUN.
- DRAIN covers the next `RESP_LATENCY` cycles.
- COMPARE is the single cycle after DRAIN.
- `done_o` rises at edge 2 + `SETTLE_CYCLES` + `N_PATTERNS` + `RESP_LATENCY`.
- The response to pattern k must be presented on `resp_i` exactly `RESP_LATENCY` cycles after pattern k is on `pattern_o`.
- `signature_o` is final from COMPARE onward and is stable in DONE.
- Back-to-back runs: a `start_i` in DONE re-enters SETUP on the next edge and drops `done_o` on that same edge.

## Test plan
- PRPG sequence. Set `PRPG_WIDTH`=4, `PRPG_POLY`=4'hC, `PRPG_SEED`=1, `N_PATTERNS`=16. Required: `pattern_o` in RUN shows 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1.
- Zero response, pass. Tie `resp_i`=0 with `GOLDEN`=0. Required: `signature_o`=0, `pass_o`=1 and `fail_o`=0. `done_o` rises at edge 2+4+1024+2 = 1032 after start.
- Single-response signature. Set `N_PATTERNS`=1 and `RESP_LATENCY`=2. Drive `resp_i`=32'hDEAD_BEEF only in the qualified cycle (2 cycles after RUN) and 0 elsewhere. Required: signature = 32'hDEAD_BEEF. With `GOLDEN`=0 this gives `fail_o`=1.
- Latency alignment. Drive a nonzero `resp_i` one cycle early or one cycle late. Required: the response is not compacted, and the signature differs from the aligned run.
- Abort mid-RUN, at pattern 10. Required: `test_mode_o`=0 and `busy_o`=0 on the next edge, `done_o` never rises, `pattern_o` holds, and a following `start_i` replays from `PRPG_SEED`.
- Robustness. Pulse `start_i` during RUN: required to be ignored, with end timing unchanged. Assert `rst_ni` low mid-DRAIN: required that all outputs return to their reset values without waiting for a clock edge.
